me_result_decoder: RTL

- Downstream consumer of the full-search motion estimation core's result interface (min_sad, min_mvec, ack).
- Converts each linear best-match index into signed (dx, dy) displacements centred on the search window.
- Stores results in a small history FIFO for readout by the display and debug logic on the FPGA top level.
- Replaces raw min_mvec display with human-readable vectors.

---
 rtl/me_result_decoder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/me_result_decoder.sv
// Turns ME-core best-match indices into signed (dx, dy) around the window centre and keeps a
// small history FIFO. Defining ME_RESULT_BEST_EN builds the lowest-SAD tracker on best_*.
module me_result_decoder #(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    parameter int DEPTH        = 4,
    localparam int SAD_WIDTH   = $clog2(TB_LENGTH**2) + PE_OUT_WIDTH,
    localparam int RANGE       = SW_LENGTH - TB_LENGTH + 1,
    localparam int CNT_WIDTH   = $clog2(RANGE**2),
    localparam int VEC_WIDTH   = $clog2(RANGE) + 1,
    localparam int CENTER      = (RANGE - 1) / 2,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                 RSTN,
    input  logic                 clk,
    input  logic                 ack,
    input  logic [SAD_WIDTH-1:0] min_sad,
    input  logic [CNT_WIDTH-1:0] min_mvec,
    output logic                 busy,
    output logic                 empty,
    output logic                 full,
    output logic [CW-1:0]        count,
    input  logic                 pop,
    output logic [SAD_WIDTH-1:0] head_sad,
    output logic [VEC_WIDTH-1:0] head_dx,
    output logic [VEC_WIDTH-1:0] head_dy,
    output logic                 head_err,
    output logic                 overflow,
    output logic                 miss,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [VEC_WIDTH-1:0] best_dx,
    output logic [VEC_WIDTH-1:0] best_dy,
    output logic [1:0]           state_dbg
);
    localparam int QW = $clog2(RANGE);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = SAD_WIDTH + 2 * VEC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] RANGE_C  = CNT_WIDTH'(RANGE);
    localparam logic [QW-1:0]        QMAX     = QW'(RANGE - 1);
    localparam logic [VEC_WIDTH-1:0] CENTER_V = VEC_WIDTH'(CENTER);
    localparam logic [CNT_WIDTH:0]   LIMIT    = (CNT_WIDTH + 1)'(RANGE * RANGE);
    localparam logic [CW-1:0]        FULL_C   = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_PUSH = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic                   ack_d_q, armed_q;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [QW-1:0]          q_q, q_d;
    logic [SAD_WIDTH-1:0]   sad_q, sad_d;
    logic                   err_q, err_d;
    logic [VEC_WIDTH-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                   miss_q, miss_d;
    logic                   ack_rise;

    // armed_q stays low until ack has been seen low, so an ack held across reset release is ignored.
    assign ack_rise = ack & ~ack_d_q & armed_q;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            ack_d_q <= 1'b0;
            armed_q <= 1'b0;
            rem_q   <= '0;
            q_q     <= '0;
            sad_q   <= '0;
            err_q   <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_d_q <= ack;
            armed_q <= armed_q | ~ack;
            rem_q   <= rem_d;
            q_q     <= q_d;
            sad_q   <= sad_d;
            err_q   <= err_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        sad_d   = sad_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        miss_d  = miss_q | (ack_rise & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (ack_rise) begin
                    state_d = S_DIV;
                    rem_d   = min_mvec;
                    q_d     = '0;
                    sad_d   = min_sad;
                    err_d   = ({1'b0, min_mvec} >= LIMIT);
                end
            end
            S_DIV: begin
                // q saturates at RANGE-1 so out-of-range indices still terminate.
                if (rem_q >= RANGE_C && q_q < QMAX) begin
                    rem_d = rem_q - RANGE_C;
                    q_d   = q_q + QW'(1);
                end else begin
                    dx_d    = err_q ? '0 : VEC_WIDTH'(rem_q) - CENTER_V;
                    dy_d    = err_q ? '0 : VEC_WIDTH'(q_q) - CENTER_V;
                    state_d = S_PUSH;
                end
            end
            S_PUSH:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] head_q, head_d, new_entry;
    logic          overflow_q, overflow_d;
    logic          push, do_pop, is_full;

    assign push      = (state_q == S_PUSH);
    assign is_full   = (count_q == FULL_C);
    assign do_pop    = pop & (count_q != '0);
    assign new_entry = {sad_q, dx_q, dy_q, err_q};

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        head_d     = head_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else if (is_full) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
        end
        // The new head may be the entry being written this same cycle.
        if (push || do_pop)
            head_d = (push && wr_ptr_q == rd_ptr_d) ? new_entry : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign empty     = (count_q == '0);
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign miss      = miss_q;
    assign state_dbg = state_q;
    assign head_sad  = head_q[EW-1 -: SAD_WIDTH];
    assign head_dx   = head_q[2*VEC_WIDTH : VEC_WIDTH+1];
    assign head_dy   = head_q[VEC_WIDTH:1];
    assign head_err  = head_q[0];

`ifdef ME_RESULT_BEST_EN
    logic [SAD_WIDTH-1:0] best_sad_q;
    logic [VEC_WIDTH-1:0] best_dx_q, best_dy_q;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            best_sad_q <= '1;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
        end else if (push && !err_q && sad_q < best_sad_q) begin
            best_sad_q <= sad_q;
            best_dx_q  <= dx_q;
            best_dy_q  <= dy_q;
        end
    end

    assign best_sad = best_sad_q;
    assign best_dx  = best_dx_q;
    assign best_dy  = best_dy_q;
`else
    assign best_sad = '0;
    assign best_dx  = '0;
    assign best_dy  = '0;
`endif

endmodule
